// File: rtl/seq_magnitude_comparator.sv
// Iterative magnitude comparator: compares two WIDTH-bit operands CHUNK bits
// per cycle, most significant chunk first, stopping at the first differing
// chunk. Optional two's-complement mode biases the sign bit of the top chunk.
module seq_magnitude_comparator #(
  parameter int WIDTH     = 16,
  parameter int CHUNK     = 4,
  parameter bit SIGNED_EN = 1'b1,
  localparam int NCHUNK   = WIDTH / CHUNK,
  localparam int CNT_W    = $clog2(NCHUNK + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             aeqb,
  output logic             altb,
  output logic             agtb,
  output logic [CNT_W-1:0] cmp_chunks
);

  localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               sm_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CHUNK-1:0]   ca, cb;
  logic               top_chunk;
  logic               chunk_gt, chunk_lt;

  // Extract chunk i (0 = least significant) from an operand.
  function automatic logic [CHUNK-1:0] chunk_sel(input logic [WIDTH-1:0] v,
                                                 input logic [IDX_W-1:0] i);
    logic [WIDTH-1:0] s;
    s = v >> (CHUNK * int'(i));
    return s[CHUNK-1:0];
  endfunction

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so the top chunk can still be compared with a plain unsigned compare.
  function automatic logic [CHUNK-1:0] sign_bias(input logic [CHUNK-1:0] c,
                                                 input logic en);
    logic [CHUNK-1:0] m;
    m          = '0;
    m[CHUNK-1] = en;
    return c ^ m;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Chunk compare, next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    top_chunk = (idx_q == IDX_W'(NCHUNK - 1));
    ca        = sign_bias(chunk_sel(a_q, idx_q), sm_q & top_chunk);
    cb        = sign_bias(chunk_sel(b_q, idx_q), sm_q & top_chunk);
    chunk_gt  = (ca > cb);
    chunk_lt  = (ca < cb);
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = COMPARE;
      end
      COMPARE: begin
        if (chunk_gt || chunk_lt || (idx_q == '0)) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, chunk walk, result flags and chunk count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      sm_q       <= 1'b0;
      idx_q      <= '0;
      cmp_chunks <= '0;
      aeqb       <= 1'b0;
      altb       <= 1'b0;
      agtb       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            sm_q       <= signed_mode & SIGNED_EN;
            idx_q      <= IDX_W'(NCHUNK - 1);
            cmp_chunks <= '0;
            aeqb       <= 1'b0;
            altb       <= 1'b0;
            agtb       <= 1'b0;
          end
        end
        COMPARE: begin
          cmp_chunks <= cmp_chunks + CNT_W'(1);
          if (chunk_gt)           agtb  <= 1'b1;
          else if (chunk_lt)      altb  <= 1'b1;
          else if (idx_q == '0)   aeqb  <= 1'b1;
          else                    idx_q <= idx_q - IDX_W'(1);
        end
        DONE: begin
          if (out_ready) begin
            aeqb <= 1'b0;
            altb <= 1'b0;
            agtb <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench for seq_magnitude_comparator (WIDTH=16, CHUNK=4, signed on).
module tb_seq_magnitude_comparator;

  localparam int WIDTH = 16;
  localparam int CNT_W = 3;

  typedef struct packed {
    logic             eq;
    logic             lt;
    logic             gt;
    logic [CNT_W-1:0] k;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic             aeqb, altb, agtb;
  logic [CNT_W-1:0] cmp_chunks;

  exp_t exp_q[$];
  int   nvec = 0;
  int   nerr = 0;

  seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4), .SIGNED_EN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .signed_mode(signed_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .aeqb       (aeqb),
    .altb       (altb),
    .agtb       (agtb),
    .cmp_chunks (cmp_chunks)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: on each result handshake pop the expected response and compare.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) check("onehot", int'(aeqb) + int'(altb) + int'(agtb), 1);
      else           check("flags_idle", {aeqb, altb, agtb}, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("flags", {aeqb, altb, agtb}, {e.eq, e.lt, e.gt});
          check("cmp_chunks", cmp_chunks, e.k);
        end
      end
    end
  end

  // Issue one compare from IDLE (called #1 after a rising edge) and check latency.
  task automatic run(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                     input logic sm, input logic eq, input logic lt,
                     input logic gt, input int k);
    int edges;
    exp_q.push_back('{eq: eq, lt: lt, gt: gt, k: CNT_W'(k)});
    check("in_ready_idle", in_ready, 1);
    a = va; b = vb; signed_mode = sm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check("latency", edges, k);
    while (out_valid && edges < 80) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_flags", {aeqb, altb, agtb}, 0);
    check("rst_cmp_chunks", cmp_chunks, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(16'h1234, 16'h1234, 1'b0, 1, 0, 0, 4);
    run(16'h8000, 16'h7FFF, 1'b0, 0, 0, 1, 1);
    run(16'h8000, 16'h7FFF, 1'b1, 0, 1, 0, 1);
    run(16'h0A10, 16'h0A01, 1'b0, 0, 0, 1, 3);
    run(16'hFFFF, 16'h0000, 1'b1, 0, 1, 0, 1);
    run(16'hFFFF, 16'h0000, 1'b0, 0, 0, 1, 1);
    run(16'h9000, 16'hA000, 1'b1, 0, 1, 0, 1);
    run(16'h0005, 16'h0003, 1'b1, 0, 0, 1, 4);
    run(16'h1234, 16'h1234, 1'b1, 1, 0, 0, 4);
    run(16'h0012, 16'h0021, 1'b0, 0, 1, 0, 3);

    // Back-pressure in DONE while the source keeps changing its inputs.
    out_ready = 1'b0;
    exp_q.push_back('{eq: 1'b0, lt: 1'b0, gt: 1'b1, k: CNT_W'(3)});
    a = 16'h0A10; b = 16'h0A01; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check("bp_latency", edges, 3);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid; a = ~a; b = b + 16'h1111; signed_mode = ~signed_mode;
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_flags", {aeqb, altb, agtb}, 3'b001);
      check("bp_cmp_chunks", cmp_chunks, 3);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_flags", {aeqb, altb, agtb}, 0);

    // Reset in the middle of a compare aborts it.
    a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_cmp_chunks", cmp_chunks, 2);
    check("mid_out_valid", out_valid, 0);
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_flags", {aeqb, altb, agtb}, 0);
    check("abort_cmp_chunks", cmp_chunks, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run(16'h0000, 16'h0000, 1'b0, 1, 0, 0, 4);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
